// File: rtl/seq_wide_adder_pkg.sv
// rtl/seq_wide_adder_pkg.sv - shared types and constants for the sequential wide adder
// Purpose: FSM state encoding and the default operand width.
// Ports: none (package).
package seq_wide_adder_pkg;

   localparam int DEFAULT_NBYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_wide_adder_if.sv
// rtl/seq_wide_adder_if.sv - request/result bundle for the sequential wide adder
// Purpose: groups the operation request and result signals.
// Ports (master drives): start, sub, a, b.
// Ports (slave drives):  busy, done, sum, cout, ovf.
interface seq_wide_adder_if
   import seq_wide_adder_pkg::*;
#(
   parameter int NBYTES = DEFAULT_NBYTES
) ();

   logic                  start;
   logic                  sub;
   logic [8*NBYTES-1:0]   a;
   logic [8*NBYTES-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [8*NBYTES-1:0]   sum;
   logic                  cout;
   logic                  ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/seq_wide_adder_rca.sv
// rtl/seq_wide_adder_rca.sv - 8-bit ripple-carry adder
// Purpose: purely combinational byte adder shared by every byte of a wide operation.
// Ports: a, b (8-bit addends), cin (carry in), sum (8-bit result), cout (carry out).
module rca (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[8];
   end

endmodule

// File: rtl/seq_wide_adder.sv
// rtl/seq_wide_adder.sv - multi-cycle wide add/subtract over one 8-bit adder
// Purpose: latches an operand pair, feeds one byte per clock (LSB first) through
//          a single rca, and assembles the wide sum with carry and overflow flags.
// Ports: clk, rst_n (sync, active-low);
//        bus (slave): start/sub/a/b in; busy/done/sum/cout/ovf out.
module seq_wide_adder
   import seq_wide_adder_pkg::*;
#(
   parameter int NBYTES = DEFAULT_NBYTES
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_wide_adder_if.slave   bus
);

   localparam int W     = 8 * NBYTES;
   localparam int IDX_W = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_t             state_q, state_d;
   logic [W-1:0]       opa_q, opb_q, sum_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q, cout_q, ovf_q;

   logic [7:0]         byte_a, byte_b, add_sum;
   logic               add_cout;

   // Byte-select mux in front of the shared adder.
   always_comb begin
      byte_a = '0;
      byte_b = '0;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            byte_a = opa_q[8*k +: 8];
            byte_b = opb_q[8*k +: 8];
         end
      end
   end

   rca u_rca (
      .a    (byte_a),
      .b    (byte_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            if (idx_q == LAST_IDX) state_d = ST_DONE;
         end
         ST_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters
   // as the initial carry, so the byte loop is identical for both operations.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  opa_q   <= bus.a;
                  opb_q   <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            ST_RUN: begin
               for (int k = 0; k < NBYTES; k++) begin
                  if (idx_q == IDX_W'(k)) sum_q[8*k +: 8] <= add_sum;
               end
               carry_q <= add_cout;
               if (idx_q == LAST_IDX) begin
                  // Wrap to zero instead of counting past the last byte.
                  idx_q  <= '0;
                  cout_q <= add_cout;
                  ovf_q  <= (byte_a[7] == byte_b[7]) && (add_sum[7] != byte_a[7]);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// tb/tb_seq_wide_adder.sv - scoreboard bench for seq_wide_adder
module tb_seq_wide_adder;

   localparam int NB = 4;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      int          due;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_wide_adder_if #(.NBYTES(NB)) bus ();

   seq_wide_adder #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         check("done_one_cycle", prev_done, 1'b0);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 required done=0", cyc);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_sum"},  bus.sum,  mon_e.sum);
            check({mon_e.name, "_cout"}, bus.cout, mon_e.cout);
            check({mon_e.name, "_ovf"},  bus.ovf,  mon_e.ovf);
            check({mon_e.name, "_lat"},  cyc,      mon_e.due);
            check({mon_e.name, "_busy"}, bus.busy, 1'b1);
         end
      end
      prev_done = bus.done;
   end

   // Drives start for one cycle; the accepting edge is the next posedge,
   // so done is expected in the negedge window 5 cycles later.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input string nm, input bit expect_it);
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      bus.sub = s;
      bus.start = 1'b1;
      if (expect_it) sb.push_back('{es, ec, eo, cyc + NB + 1, nm});
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = ~a;
      bus.b = 32'h5A5A_5A5A;
      bus.sub = ~s;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending results required 0", nm, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.sub = 1'b0;
      bus.a = '0;
      bus.b = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_sum",  bus.sum,  32'h0);
      check("rst_cout", bus.cout, 1'b0);
      check("rst_ovf",  bus.ovf,  1'b0);
      rst_n = 1'b1;

      issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1", 1'b1);
      drain("add_ff_1");
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap", 1'b1);
      drain("add_wrap");
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf", 1'b1);
      drain("add_ovf");
      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf", 1'b1);
      drain("sub_ovf");
      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow", 1'b1);
      drain("sub_borrow");
      issue(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_equal", 1'b1);
      drain("sub_equal");

      // Starts while busy (cycle 2 and the done cycle 5) must be ignored;
      // the start in cycle 6 is accepted.
      issue(32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0, "busy_first", 1'b1);
      @(negedge clk);
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h0BAD_F00D;
      bus.sub = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.a = 32'hCAFE_0000;
      bus.b = 32'h0000_CAFE;
      bus.start = 1'b1;
      issue(32'hF000_0000, 32'h1000_0000, 1'b1, 32'hE000_0000, 1'b1, 1'b0, "after_done", 1'b1);
      drain("after_done");

      // Reset in the middle of RUN abandons the operation.
      issue(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b0, "aborted", 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_sum",  bus.sum,  32'h0);
      check("midrst_cout", bus.cout, 1'b0);
      check("midrst_ovf",  bus.ovf,  1'b0);
      repeat (10) @(negedge clk);
      issue(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, "post_rst", 1'b1);
      drain("post_rst");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
